cvita_pkt_monitor: RTL

- Synthesizable, passive multi-stream CVITA packet monitor. It taps NUM_STREAMS 64-bit AXI-Stream links without affecting their handshakes.
- Per packet it extracts the header and timestamp, accumulates payload statistics (count, sum, min, max, xor-crc), and checks the length field and sequence number.
- It emits one result record per packet on a single arbitrated output port.
- Used in-fabric for link BIST and debug readback, alongside the simulation-side stats collector.

---
 rtl/cvita_pkt_monitor_if.sv | 38 +++
 rtl/cvita_pkt_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/cvita_pkt_monitor_if.sv
// Tap and result bundle for the CVITA packet monitor.
// Master drives the tapped links and o_ready; slave is the monitor.
interface cvita_pkt_monitor_if #(
  parameter int NUM_STREAMS = 4,
  parameter int SIDW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) ();

  logic [64*NUM_STREAMS-1:0] mon_tdata;
  logic [NUM_STREAMS-1:0]    mon_tlast;
  logic [NUM_STREAMS-1:0]    mon_tvalid;
  logic [NUM_STREAMS-1:0]    mon_tready;

  logic            o_valid;
  logic            o_ready;
  logic [SIDW-1:0] o_stream;
  logic [127:0]    o_hdr;
  logic [31:0]     o_count;
  logic [63:0]     o_sum;
  logic [63:0]     o_min;
  logic [63:0]     o_max;
  logic [63:0]     o_crc;
  logic [2:0]      o_err;

  modport master (
    output mon_tdata, mon_tlast, mon_tvalid, mon_tready,
    output o_ready,
    input  o_valid, o_stream, o_hdr, o_count,
    input  o_sum, o_min, o_max, o_crc, o_err
  );

  modport slave (
    input  mon_tdata, mon_tlast, mon_tvalid, mon_tready,
    input  o_ready,
    output o_valid, o_stream, o_hdr, o_count,
    output o_sum, o_min, o_max, o_crc, o_err
  );

endinterface

// File: rtl/cvita_pkt_monitor.sv
// Passive multi-stream CVITA packet monitor: per-packet
// header/time/stats/length/seq checks, round-robin result port.
module cvita_pkt_monitor #(
  parameter int NUM_STREAMS = 4,
  parameter int SEQ_CHECK = 1,
  parameter int SIDW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input logic                clk,
  input logic                reset_n,
  cvita_pkt_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_HDR,
    S_TIME,
    S_PAY
  } state_t;

  typedef struct packed {
    logic [127:0] hdr;
    logic [31:0]  count;
    logic [63:0]  sum;
    logic [63:0]  vmin;
    logic [63:0]  vmax;
    logic [63:0]  crc;
    logic [2:0]   err;
  } rec_t;

  logic slot_full [NUM_STREAMS];
  rec_t slot_rec  [NUM_STREAMS];
  logic emptied   [NUM_STREAMS];

  logic            gnt_v;
  logic [SIDW-1:0] gnt;
  logic [SIDW-1:0] rr_q;
  logic            take;
  logic            o_valid_q;
  logic [SIDW-1:0] o_stream_q;
  rec_t            o_rec_q;

  assign take = (!o_valid_q || bus.o_ready) && gnt_v;

  for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_str
    logic [63:0] d;
    logic        beat;
    logic        done;
    state_t      st_q;
    logic [63:0] hdr_q, ts_q, sum_q;
    logic [63:0] min_q, max_q, crc_q;
    logic [31:0] cnt_q, w_q;
    logic [63:0] n_hdr, n_ts, n_sum;
    logic [63:0] n_min, n_max, n_crc;
    logic [31:0] n_cnt, n_w;
    logic [11:0] exp_q;
    logic        exp_v;
    logic [34:0] w8, len35;
    logic        len_err, seq_err;
    rec_t        rec;

    assign d    = bus.mon_tdata[64*k +: 64];
    assign beat = bus.mon_tvalid[k] & bus.mon_tready[k];
    assign done = beat & bus.mon_tlast[k];

    // Next-state packet context including the current beat.
    always_comb begin
      n_hdr = hdr_q;
      n_ts  = ts_q;
      n_cnt = cnt_q;
      n_sum = sum_q;
      n_min = min_q;
      n_max = max_q;
      n_crc = crc_q;
      n_w   = w_q + 32'd1;
      unique case (st_q)
        S_HDR: begin
          n_hdr = d;
          n_ts  = '0;
          n_cnt = '0;
          n_sum = '0;
          n_min = '1;
          n_max = '0;
          n_crc = '0;
          n_w   = 32'd1;
        end
        S_TIME: n_ts = d;
        S_PAY: begin
          n_cnt = cnt_q + 32'd1;
          n_sum = sum_q + d;
          n_crc = crc_q ^ d;
          n_min = (d < min_q) ? d : min_q;
          n_max = (d > max_q) ? d : max_q;
        end
        default: ;
      endcase
    end

    assign w8      = {n_w, 3'b000};
    assign len35   = {19'd0, n_hdr[47:32]};
    assign len_err = !((len35 == w8) ||
                       (len35 == w8 - 35'd4));
    assign seq_err = (SEQ_CHECK != 0) && exp_v &&
                     (n_hdr[59:48] != exp_q);

    // Record as it would be emitted on this beat.
    always_comb begin
      rec       = '0;
      rec.hdr   = {n_hdr, n_ts};
      rec.count = n_cnt;
      rec.sum   = n_sum;
      rec.vmin  = n_min;
      rec.vmax  = n_max;
      rec.crc   = n_crc;
      rec.err   = {1'b0, seq_err, len_err};
    end

    assign emptied[k] = take && (gnt == SIDW'(k));

    // Packet parser FSM and running statistics.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st_q  <= S_HDR;
        hdr_q <= '0;
        ts_q  <= '0;
        cnt_q <= '0;
        sum_q <= '0;
        min_q <= '1;
        max_q <= '0;
        crc_q <= '0;
        w_q   <= '0;
      end else if (beat) begin
        hdr_q <= n_hdr;
        ts_q  <= n_ts;
        cnt_q <= n_cnt;
        sum_q <= n_sum;
        min_q <= n_min;
        max_q <= n_max;
        crc_q <= n_crc;
        w_q   <= n_w;
        if (bus.mon_tlast[k])
          st_q <= S_HDR;
        else if (st_q == S_HDR)
          st_q <= d[61] ? S_TIME : S_PAY;
        else
          st_q <= S_PAY;
      end
    end

    // Expected sequence number tracking.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        exp_v <= 1'b0;
        exp_q <= '0;
      end else if (done) begin
        exp_v <= 1'b1;
        exp_q <= n_hdr[59:48] + 12'd1;
      end
    end

    // Single-entry result slot with drop marking.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        slot_full[k] <= 1'b0;
        slot_rec[k]  <= '0;
      end else if (done) begin
        if (!slot_full[k] || emptied[k]) begin
          slot_full[k] <= 1'b1;
          slot_rec[k]  <= rec;
        end else begin
          slot_rec[k].err[2] <= 1'b1;
        end
      end else if (emptied[k]) begin
        slot_full[k] <= 1'b0;
      end
    end
  end

  // Round-robin pick of the first full slot from rr_q.
  always_comb begin
    gnt_v = 1'b0;
    gnt   = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (!gnt_v &&
          slot_full[(int'(rr_q) + i) % NUM_STREAMS]) begin
        gnt_v = 1'b1;
        gnt   = SIDW'((int'(rr_q) + i) % NUM_STREAMS);
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid_q  <= 1'b0;
      o_stream_q <= '0;
      o_rec_q    <= '0;
      rr_q       <= '0;
    end else if (!o_valid_q || bus.o_ready) begin
      o_valid_q <= gnt_v;
      if (gnt_v) begin
        o_stream_q <= gnt;
        o_rec_q    <= slot_rec[gnt];
        if (gnt == SIDW'(NUM_STREAMS - 1))
          rr_q <= '0;
        else
          rr_q <= gnt + SIDW'(1);
      end
    end
  end

  assign bus.o_valid  = o_valid_q;
  assign bus.o_stream = o_stream_q;
  assign bus.o_hdr    = o_rec_q.hdr;
  assign bus.o_count  = o_rec_q.count;
  assign bus.o_sum    = o_rec_q.sum;
  assign bus.o_min    = o_rec_q.vmin;
  assign bus.o_max    = o_rec_q.vmax;
  assign bus.o_crc    = o_rec_q.crc;
  assign bus.o_err    = o_rec_q.err;

endmodule
